// File: rtl/mips_pkg.sv
// ============================================================================
// mips_pkg
// Shared encodings and constants for the MIPS pipeline fetch logic.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mips_pkg;

  typedef enum logic [1:0] {
    PC_SRC_SEQ = 2'b00,
    PC_SRC_BR  = 2'b01,
    PC_SRC_J   = 2'b10,
    PC_SRC_JR  = 2'b11
  } pc_src_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// sat_counter
// Enable-driven up counter that sticks at all-ones instead of wrapping.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_en && (r_count != {W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/if_stage.sv
// ============================================================================
// if_stage
// MIPS instruction fetch: PC register, next-PC select, IF/ID register and
// saturating stall/flush event counters.
// Revision: 1.0
// ============================================================================
`default_nettype none

module if_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             PC_write_i,
  input  logic             IFID_write_i,
  input  logic             IFID_flush_i,
  input  logic [1:0]       pc_src_i,
  input  logic [31:0]      branch_target_i,
  input  logic [25:0]      jump_index_i,
  input  logic [31:0]      jr_target_i,
  input  logic [31:0]      instr_i,
  output logic [31:0]      pc_o,
  output logic [31:0]      ifid_instr_o,
  output logic [31:0]      ifid_pc4_o,
  output logic             ifid_valid_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  logic [31:0] r_pc;
  logic [31:0] r_ifid_instr;
  logic [31:0] r_ifid_pc4;
  logic        r_ifid_valid;
  logic [31:0] w_pc4;
  logic [31:0] w_next_pc;
  logic        w_flush_take;

  assign w_pc4 = r_pc + 32'd4;

  // The jump region comes from the j/jal's own PC+4, which sits in IF/ID.
  always_comb begin
    w_next_pc = w_pc4;
    case (pc_src_e'(pc_src_i))
      PC_SRC_SEQ: w_next_pc = w_pc4;
      PC_SRC_BR:  w_next_pc = branch_target_i;
      PC_SRC_J:   w_next_pc = {r_ifid_pc4[31:28], jump_index_i, 2'b00};
      PC_SRC_JR:  w_next_pc = jr_target_i;
      default:    w_next_pc = w_pc4;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc <= RESET_PC;
    end else if (PC_write_i) begin
      r_pc <= w_next_pc;
    end
  end

  // A held IF/ID beats a flush so a stalled branch in ID survives.
  assign w_flush_take = IFID_write_i && !IFID_flush_i;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ifid_instr <= NOP_INSTR;
      r_ifid_pc4   <= 32'd0;
      r_ifid_valid <= 1'b0;
    end else if (IFID_write_i) begin
      if (!IFID_flush_i) begin
        r_ifid_instr <= NOP_INSTR;
        r_ifid_pc4   <= 32'd0;
        r_ifid_valid <= 1'b0;
      end else begin
        r_ifid_instr <= instr_i;
        r_ifid_pc4   <= w_pc4;
        r_ifid_valid <= 1'b1;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .rst_n   (reset),
    .i_en    (!PC_write_i),
    .o_count (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .rst_n   (reset),
    .i_en    (w_flush_take),
    .o_count (flush_cnt_o)
  );

  assign pc_o         = r_pc;
  assign ifid_instr_o = r_ifid_instr;
  assign ifid_pc4_o   = r_ifid_pc4;
  assign ifid_valid_o = r_ifid_valid;

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// ============================================================================
// tb_if_stage
// Directed scoreboard bench for if_stage; imem returns the address as data.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_if_stage;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic [15:0] stall;
    logic [15:0] flush;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        PC_write_i;
  logic        IFID_write_i;
  logic        IFID_flush_i;
  logic [1:0]  pc_src_i;
  logic [31:0] branch_target_i;
  logic [25:0] jump_index_i;
  logic [31:0] jr_target_i;
  logic [31:0] instr_i;
  logic [31:0] pc_o;
  logic [31:0] ifid_instr_o;
  logic [31:0] ifid_pc4_o;
  logic        ifid_valid_o;
  logic [15:0] stall_cnt_o;
  logic [15:0] flush_cnt_o;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  if_stage #(.RESET_PC(32'h0040_0000), .CNT_W(16)) dut (
    .clk             (clk),
    .reset           (reset),
    .PC_write_i      (PC_write_i),
    .IFID_write_i    (IFID_write_i),
    .IFID_flush_i    (IFID_flush_i),
    .pc_src_i        (pc_src_i),
    .branch_target_i (branch_target_i),
    .jump_index_i    (jump_index_i),
    .jr_target_i     (jr_target_i),
    .instr_i         (instr_i),
    .pc_o            (pc_o),
    .ifid_instr_o    (ifid_instr_o),
    .ifid_pc4_o      (ifid_pc4_o),
    .ifid_valid_o    (ifid_valid_o),
    .stall_cnt_o     (stall_cnt_o),
    .flush_cnt_o     (flush_cnt_o)
  );

  assign instr_i = pc_o;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic chk_all(input exp_t e);
    chk({e.tag, ".pc"},    pc_o,                 e.pc);
    chk({e.tag, ".instr"}, ifid_instr_o,         e.instr);
    chk({e.tag, ".pc4"},   ifid_pc4_o,           e.pc4);
    chk({e.tag, ".valid"}, {31'd0, ifid_valid_o}, {31'd0, e.valid});
    chk({e.tag, ".stall"}, {16'd0, stall_cnt_o},  {16'd0, e.stall});
    chk({e.tag, ".flush"}, {16'd0, flush_cnt_o},  {16'd0, e.flush});
  endtask

  // Monitor: outputs are registered, so each expectation is checked on the
  // falling edge after the rising edge it was issued for.
  always @(negedge clk) begin
    if (q.size() > 0) chk_all(q.pop_front());
  end

  task automatic drive(input logic pcw, input logic ifw, input logic fl,
                       input logic [1:0] src, input logic [31:0] bt,
                       input logic [25:0] ji, input logic [31:0] jr);
    PC_write_i      = pcw;
    IFID_write_i    = ifw;
    IFID_flush_i    = fl;
    pc_src_i        = src;
    branch_target_i = bt;
    jump_index_i    = ji;
    jr_target_i     = jr;
  endtask

  task automatic step(input string tag, input logic push,
                      input logic [31:0] pc, input logic [31:0] instr,
                      input logic [31:0] pc4, input logic valid,
                      input logic [15:0] stall, input logic [15:0] flush);
    exp_t e;
    e.tag = tag; e.pc = pc; e.instr = instr; e.pc4 = pc4;
    e.valid = valid; e.stall = stall; e.flush = flush;
    if (push) q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t r;
    reset = 1'b0;
    drive(1, 1, 1, 2'b00, 32'h0, 26'h0, 32'h0);
    #12;
    r.tag = "reset"; r.pc = 32'h0040_0000; r.instr = 32'h0; r.pc4 = 32'h0;
    r.valid = 1'b0; r.stall = 16'h0; r.flush = 16'h0;
    chk_all(r);
    @(negedge clk); #1;
    reset = 1'b1;

    step("seq1", 1, 32'h0040_0004, 32'h0040_0000, 32'h0040_0004, 1, 16'd0, 16'd0);
    step("seq2", 1, 32'h0040_0008, 32'h0040_0004, 32'h0040_0008, 1, 16'd0, 16'd0);
    drive(0, 0, 1, 2'b00, 32'h0, 26'h0, 32'h0);
    step("stall", 1, 32'h0040_0008, 32'h0040_0004, 32'h0040_0008, 1, 16'd1, 16'd0);
    drive(1, 1, 1, 2'b00, 32'h0, 26'h0, 32'h0);
    step("resume", 1, 32'h0040_000C, 32'h0040_0008, 32'h0040_000C, 1, 16'd1, 16'd0);
    drive(1, 1, 0, 2'b01, 32'h0040_0100, 26'h0, 32'h0);
    step("branch", 1, 32'h0040_0100, 32'h0, 32'h0, 0, 16'd1, 16'd1);
    drive(1, 1, 1, 2'b00, 32'h0, 26'h0, 32'h0);
    step("postbr", 1, 32'h0040_0104, 32'h0040_0100, 32'h0040_0104, 1, 16'd1, 16'd1);
    drive(1, 1, 1, 2'b11, 32'h0, 26'h0, 32'h1000_000C);
    step("jr_hi", 1, 32'h1000_000C, 32'h0040_0104, 32'h0040_0108, 1, 16'd1, 16'd1);
    drive(1, 1, 1, 2'b00, 32'h0, 26'h0, 32'h0);
    step("seq_hi", 1, 32'h1000_0010, 32'h1000_000C, 32'h1000_0010, 1, 16'd1, 16'd1);
    drive(1, 1, 1, 2'b10, 32'h0, 26'h000_0040, 32'h0);
    step("j", 1, 32'h1000_0100, 32'h1000_0010, 32'h1000_0014, 1, 16'd1, 16'd1);
    drive(1, 1, 1, 2'b11, 32'h0, 26'h0, 32'h0040_0020);
    step("jr", 1, 32'h0040_0020, 32'h1000_0100, 32'h1000_0104, 1, 16'd1, 16'd1);
    drive(1, 0, 0, 2'b00, 32'h0, 26'h0, 32'h0);
    step("hold_vs_flush", 1, 32'h0040_0024, 32'h1000_0100, 32'h1000_0104, 1, 16'd1, 16'd1);
    drive(1, 1, 0, 2'b00, 32'h0, 26'h0, 32'h0);
    step("flush2", 1, 32'h0040_0028, 32'h0, 32'h0, 0, 16'd1, 16'd2);
    drive(1, 1, 1, 2'b11, 32'h0, 26'h0, 32'hFFFF_FFFC);
    step("to_top", 1, 32'hFFFF_FFFC, 32'h0040_0028, 32'h0040_002C, 1, 16'd1, 16'd2);
    drive(1, 1, 1, 2'b00, 32'h0, 26'h0, 32'h0);
    step("wrap", 1, 32'h0000_0000, 32'hFFFF_FFFC, 32'h0000_0000, 1, 16'd1, 16'd2);

    // Long stall: count starts at 1, so it reaches FFFE after 65533 cycles.
    drive(0, 0, 1, 2'b01, 32'h0040_0100, 26'h0, 32'h0);
    for (int i = 1; i <= 65541; i++) begin
      if (i == 65533)
        step("sat_m1", 1, 32'h0, 32'hFFFF_FFFC, 32'h0, 1, 16'hFFFE, 16'd2);
      else if (i == 65534)
        step("sat", 1, 32'h0, 32'hFFFF_FFFC, 32'h0, 1, 16'hFFFF, 16'd2);
      else if (i == 65541)
        step("sat_hold", 1, 32'h0, 32'hFFFF_FFFC, 32'h0, 1, 16'hFFFF, 16'd2);
      else
        step("sat_run", 0, 32'h0, 32'h0, 32'h0, 0, 16'h0, 16'h0);
    end

    drive(1, 1, 1, 2'b00, 32'h0, 26'h0, 32'h0);
    step("post_sat", 1, 32'h0000_0004, 32'h0, 32'h0000_0004, 1, 16'hFFFF, 16'd2);

    #2;
    reset = 1'b0;
    #1;
    r.tag = "async_rst";
    chk_all(r);
    @(negedge clk); #1;
    r.tag = "rst_held";
    chk_all(r);
    reset = 1'b1;
    step("rst_first", 1, 32'h0040_0004, 32'h0040_0000, 32'h0040_0004, 1, 16'd0, 16'd0);

    @(negedge clk); #1;
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline. Holds the PC register, selects the next PC (sequential, branch, j/jal, jr), drives the instruction-memory address, and owns the IF/ID pipeline register.
- Consumes the hazard unit's PC_write, IFID_write and IFID_flush (active-low flush) outputs; feeds the ID stage.
- Keeps saturating stall and flush event counters for performance debug.

Parameters:
- RESET_PC, 32'h0040_0000, PC value loaded on reset.
- CNT_W, 16, width of the stall and flush counters.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- PC_write_i  in  1  1 = PC may update; 0 = hold PC.
- IFID_write_i  in  1  1 = IF/ID may load; 0 = hold IF/ID.
- IFID_flush_i  in  1  active-low; 0 = clear IF/ID to a bubble.
- pc_src_i  in  2  00 = PC+4, 01 = branch target, 10 = j/jal, 11 = jr.
- branch_target_i  in  32  taken-branch target, resolved in ID.
- jump_index_i  in  26  instr[25:0] of the j/jal in ID.
- jr_target_i  in  32  forwarded rs value for jr.
- instr_i  in  32  instruction-memory read data for pc_o, combinational.
- pc_o  out  32  current PC, drives the instruction-memory address.
- ifid_instr_o  out  32  IF/ID instruction.
- ifid_pc4_o  out  32  IF/ID PC+4.
- ifid_valid_o  out  1  1 = IF/ID holds a real instruction; 0 = bubble.
- stall_cnt_o  out  CNT_W  cycles in which PC_write_i was 0.
- flush_cnt_o  out  CNT_W  cycles in which a flush was applied.

Behaviour:
- Reset (reset = 0, asynchronous):
  - pc_o = RESET_PC.
  - ifid_instr_o = 0 (NOP), ifid_pc4_o = 0, ifid_valid_o = 0.
  - Both counters = 0.
  - Reset asserted mid-stall or mid-flush discards all state. The first fetch after release is RESET_PC.
- pc4 = pc_o + 32'd4, modulo 2^32 (wraps silently).
- next_pc selection:
  - 00: pc4.
  - 01: branch_target_i.
  - 10: {ifid_pc4_o[31:28], jump_index_i, 2'b00}.
  - 11: jr_target_i.
- PC register, on each rising edge:
  - PC_write_i = 1: pc_o <= next_pc.
  - PC_write_i = 0: pc_o holds. A pc_src_i redirect is ignored that cycle. The ID instruction is also held, so it re-presents the redirect on the next cycle.
- IF/ID register, priority order per edge:
  1. IFID_write_i = 0: hold all fields. Stall wins over flush, so a branch being held in ID is never destroyed.
  2. Else IFID_flush_i = 0: instr <= 0, pc4 <= 0, valid <= 0.
  3. Else: instr <= instr_i, pc4 <= pc4, valid <= 1.
- Latency:
  - An instruction at pc_o appears on ifid_instr_o one edge later.
  - A redirect with PC_write_i = 1 takes effect on pc_o one edge later. Exactly one wrong-path slot exists, and the hazard unit's flush removes it.
- Counters:
  - stall_cnt_o increments on every edge with PC_write_i = 0.
  - flush_cnt_o increments on every edge where case 2 above is taken.
  - Both saturate at all-ones and never wrap.
- All outputs are registered except pc_o, which is the PC register itself.
- No combinational path from any input to any output.

Decomposition:
- Shared package mips_pkg: PC_SRC_SEQ/BR/J/JR encodings, NOP_INSTR = 32'h0, RESET_PC default.
- One natural sub-module: sat_counter (CNT_W wide, enable, async active-low reset), instantiated twice.
- PC logic and the IF/ID register stay inline.

Test Plan:
- Reset release, pc_src = 00, all enables 1, imem returns the address as data → pc_o = 0x00400000, 0x00400004, 0x00400008 on successive edges. ifid_pc4_o lags pc_o by one edge and equals that earlier pc_o + 4. ifid_valid_o = 1 from the 2nd edge.
- Load-use stall: PC_write = IFID_write = 0 for 1 cycle at pc_o = 0x00400008 → pc_o and IF/ID hold one extra cycle, then resume. stall_cnt_o = 1.
- Branch: pc_src = 01, branch_target = 0x00400100, IFID_flush = 0 for one cycle → pc_o = 0x00400100 next edge. IF/ID becomes a bubble (instr 0, valid 0). flush_cnt_o = 1.
- j with ifid_pc4 = 0x1000_0010, jump_index = 26'h0000040 → pc_o = 0x1000_0100. jr with jr_target = 0x0040_0020 → pc_o = 0x0040_0020.
- Simultaneous IFID_write = 0 and IFID_flush = 0 → IF/ID holds (valid stays 1) and flush_cnt_o is unchanged. Also: pc_o = 0xFFFF_FFFC with pc_src = 00 → pc_o wraps to 0.
- Hold PC_write = 0 for 2^16 + 5 cycles → stall_cnt_o saturates at 0xFFFF. Assert reset mid-run → everything returns to reset values asynchronously, without a clock edge.
